alu_rr_scheduler: RTL and testbench
===================================

// Module: alu_rr_scheduler
// PURPOSE
// - Shares one 6-bit ALU (XNOR/OR/AND and rotate-right ops) between two requesters using round-robin arbitration.
// - Accepts {A,B,OP} via valid/ready, drives registered operands to the ALU, captures R plus flags, returns them via valid/ready.
// - Sits between the two issuing datapath clients and the combinational ALU instance.
// PARAMETERS
// - W         6     operand/result width
// - OPW       2     opcode width
// - PRIO_INIT 0     requester holding priority after reset (0 or 1)
// PORTS
// - clk            in   1      single clock, rising edge
// - rst_n          in   1      reset: one clock; reset is synchronous and active-low
// - req_valid      in   2      per-requester request valid
// - req_ready      out  2      per-requester accept (one-hot or zero)
// - req_a0/req_a1  in   W      operand A, requester 0/1
// - req_b0/req_b1  in   W      operand B, requester 0/1
// - req_op0/req_op1 in  OPW    opcode, requester 0/1
// - alu_a, alu_b   out  W      registered operands to the ALU
// - alu_op         out  OPW    registered opcode to the ALU
// - alu_r          in   W      ALU result (combinational from alu_a/b/op)
// - alu_flags      in   4      {GT_ZERO,SF,CF,ZF} from the ALU
// - rsp_valid      out  2      per-requester response valid (one-hot or zero)
// - rsp_ready      in   2      per-requester response accept
// - rsp_r          out  W      captured result (shared bus, owner = rsp_id)
// - rsp_flags      out  4      captured {GT_ZERO,SF,CF,ZF}
// - rsp_err        out  1      1 = opcode was 2'b10/2'b11 (unsupported)
// - rsp_id         out  1      requester that owns the current response
// - busy           out  1      1 whenever state != IDLE
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): state=IDLE; alu_a/alu_b/alu_op/rsp_r/rsp_flags/rsp_err/rsp_id=0;
//   rsp_valid=0; priority pointer=PRIO_INIT. Mid-operation reset abandons the op with no response.
// - FSM IDLE->EXEC->RESP->IDLE; no other states.
//   IDLE: grant g = requester that is valid; if both valid, the one holding priority. req_ready[g]=1
//     combinationally, only in IDLE. On handshake: latch operands/op into alu_*, rsp_id<=g, go EXEC.
//   EXEC: alu_* stable for exactly one cycle; at edge capture alu_r/alu_flags into rsp_r/rsp_flags,
//     rsp_err<=alu_op[1]; go RESP.
//   RESP: rsp_valid[rsp_id]=1, rsp_* held stable until rsp_ready[rsp_id]=1; then go IDLE and pass
//     priority to the other requester. rsp_ready of the non-owner is ignored.
// - Latency: handshake at cycle t -> rsp_valid at t+2. Minimum 3 cycles per op; no overlap.
// - alu_* hold their last value outside EXEC (no toggling while idle).
// - Unsupported opcodes are forwarded unchanged; expected ALU response R=0, flags=4'b0001, rsp_err=1.
// - req_valid may drop before grant without error; a request is consumed only on valid&ready.
// - Fairness: with both requesters continuously valid, grants strictly alternate.
// STRUCTURE
// - Shared package alu_ctrl_pkg holds OP_XNOR_OR_AND=2'b00, OP_ROR=2'b01, the state enum
//   {IDLE,EXEC,RESP}, the flag bit indices (GT_ZERO=3,SF=2,CF=1,ZF=0), and W/OPW defaults.
// - One sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], advance, grant[1:0], pointer
//   register, synchronous active-low reset to PRIO_INIT). FSM/datapath registers stay in the top.
// - The ALU is instantiated by the parent, not inside this block.
// TESTING (bench instantiates the real ALU behind this block)
// - Reset: hold rst_n=0 two cycles with req_valid=2'b11 -> req_ready=0, rsp_valid=0, busy=0, alu_*=0.
// - Req0 A=6'b101010 B=6'b110011 OP=00 -> rsp_valid=2'b01 at t+2, rsp_r=6'b100110, flags=4'b1100.
// - Req1 A=6'b000001 B=6'b000001 OP=01 -> rsp_id=1, rsp_r=6'b100000, flags=4'b1100, rsp_err=0.
// - Both valid every cycle from reset, PRIO_INIT=0 -> grant order 0,1,0,1; each response waits for its rsp_ready.
// - Req0 A=0 B=0 OP=01, rsp_ready low 5 cycles -> rsp_r=0, flags=4'b0001 held stable; busy=1 throughout.
// - Req1 OP=2'b11 A=6'h3F B=6'h3F -> rsp_r=0, flags=4'b0001, rsp_err=1. Also: rst_n low in EXEC -> IDLE, no rsp.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request scheduler: opcodes, FSM states, flag positions, widths.
package alu_ctrl_pkg;

  localparam int W_DEF   = 6;
  localparam int OPW_DEF = 2;

  localparam logic [1:0] OP_XNOR_OR_AND = 2'b00;
  localparam logic [1:0] OP_ROR         = 2'b01;

  // Bit positions inside the 4-bit flag vector {GT_ZERO,SF,CF,ZF}.
  localparam int GT_ZERO = 3;
  localparam int SF      = 2;
  localparam int CF      = 1;
  localparam int ZF      = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Both supported opcodes have op[1]=0; anything with op[1]=1 is unsupported.
  function automatic logic op_unsupported(input logic [1:0] op);
    return (op != OP_XNOR_OR_AND) && (op != OP_ROR);
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: grants the sole requester, or the pointer holder on contention.
// Pointer moves to the requester other than the finishing owner when advance is pulsed.
module rr_arb2 #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       owner,
  output logic [1:0] grant
);

  logic ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= PRIO_INIT;
    end else if (advance) begin
      ptr <= ~owner;
    end
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant      = 2'b00;
      grant[ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Time-shares one combinational ALU between two requesters: accept, one EXEC cycle, then hold the
// response until its owner takes it. Handshake at t gives rsp_valid at t+2; one op in flight at a time.
module alu_rr_scheduler
  import alu_ctrl_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int OPW       = OPW_DEF,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [W-1:0]   req_a0,
  input  logic [W-1:0]   req_a1,
  input  logic [W-1:0]   req_b0,
  input  logic [W-1:0]   req_b1,
  input  logic [OPW-1:0] req_op0,
  input  logic [OPW-1:0] req_op1,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_r,
  input  logic [3:0]     alu_flags,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [W-1:0]   rsp_r,
  output logic [3:0]     rsp_flags,
  output logic           rsp_err,
  output logic           rsp_id,
  output logic           busy
);

  state_t     state;
  logic [1:0] grant;
  logic       accept;
  logic       rsp_done;

  rr_arb2 #(.PRIO_INIT(PRIO_INIT)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (rsp_done),
    .owner   (rsp_id),
    .grant   (grant)
  );

  // Ready is withheld during reset so nothing is consumed while the block is being cleared.
  assign req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign rsp_done  = (state == RESP) && rsp_ready[rsp_id];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_r     <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_valid <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a  <= grant[1] ? req_a1  : req_a0;
            alu_b  <= grant[1] ? req_b1  : req_b0;
            alu_op <= grant[1] ? req_op1 : req_op0;
            rsp_id <= grant[1];
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_r     <= alu_r;
          rsp_flags <= alu_flags;
          rsp_err   <= op_unsupported(alu_op[1:0]);
          rsp_valid <= rsp_id ? 2'b10 : 2'b01;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler with a behavioural ALU behind it, a transaction-level reference model
// checked every cycle, and directed literal checks for the documented vectors.
module tb_alu_rr_scheduler;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W-1:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]   req_op0, req_op1;
  logic [W-1:0] alu_a, alu_b, alu_r, rsp_r;
  logic [1:0]   alu_op;
  logic [3:0]   alu_flags, rsp_flags;
  logic         rsp_err, rsp_id, busy;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.W(W), .OPW(2), .PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .rsp_id(rsp_id),
    .busy(busy)
  );

  // ALU: 00 = XNOR, 01 = rotate A right by B mod 6, else R=0. Returns {flags, r}.
  function automatic logic [9:0] alu_f(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op);
    logic [11:0] d;
    logic [5:0]  r;
    int          s;
    r = '0;
    case (op)
      2'b00: r = ~(a ^ b);
      2'b01: begin
        s = int'(b) % 6;
        d = {a, a} >> s;
        r = d[5:0];
      end
      default: r = '0;
    endcase
    return {|r, r[5], 1'b0, (r == 6'd0), r};
  endfunction

  always_comb {alu_flags, alu_r} = alu_f(alu_a, alu_b, alu_op);

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: tracks the one transaction in flight and its age in cycles since acceptance.
  bit         m_valid = 1'b0;
  bit         m_active = 1'b0;
  int         m_age = 0;
  bit         m_prio = 1'b0;
  bit         m_id = 1'b0;
  logic [5:0] m_a = '0, m_b = '0;
  logic [1:0] m_op = '0;
  logic [9:0] m_exp = '0;
  logic [1:0] m_g;
  logic [1:0] m_rv;

  always @(negedge clk) begin
    if (req_valid == 2'b11) m_g = m_prio ? 2'b10 : 2'b01;
    else                    m_g = req_valid;
    m_rv = (m_active && m_age >= 1) ? (m_id ? 2'b10 : 2'b01) : 2'b00;
    if (m_valid) begin
      chk("m_req_ready", 32'(req_ready), 32'((!m_active && rst_n) ? m_g : 2'b00));
      chk("m_busy",      32'(busy),      32'(m_active));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("m_alu_a",     32'(alu_a),     32'(m_a));
      chk("m_alu_b",     32'(alu_b),     32'(m_b));
      chk("m_alu_op",    32'(alu_op),    32'(m_op));
      chk("m_rsp_id",    32'(rsp_id),    32'(m_id));
      if (m_rv != 2'b00) begin
        chk("m_rsp_r",     32'(rsp_r),     32'(m_exp[5:0]));
        chk("m_rsp_flags", 32'(rsp_flags), 32'(m_exp[9:6]));
        chk("m_rsp_err",   32'(rsp_err),   32'(m_op[1]));
      end
    end
    if (!rst_n) begin
      m_valid = 1'b1; m_active = 1'b0; m_age = 0; m_prio = 1'b0; m_id = 1'b0;
      m_a = '0; m_b = '0; m_op = '0;
    end else if (m_valid) begin
      if (m_active) begin
        if (m_age >= 1 && rsp_ready[m_id]) begin
          m_active = 1'b0;
          m_prio   = ~m_id;
        end else begin
          m_age++;
        end
      end else if (|req_valid) begin
        m_id     = m_g[1];
        m_a      = m_g[1] ? req_a1  : req_a0;
        m_b      = m_g[1] ? req_b1  : req_b0;
        m_op     = m_g[1] ? req_op1 : req_op0;
        m_exp    = alu_f(m_a, m_b, m_op);
        m_active = 1'b1;
        m_age    = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit id, input logic [5:0] a, input logic [5:0] b, input logic [1:0] op,
                        input int hold, input logic [5:0] er, input logic [3:0] ef, input logic ee);
    logic [1:0] oh;
    oh = id ? 2'b10 : 2'b01;
    step();
    req_valid = oh;
    rsp_ready = 2'b00;
    if (id) begin req_a1 = a; req_b1 = b; req_op1 = op; end
    else    begin req_a0 = a; req_b0 = b; req_op0 = op; end
    @(negedge clk);
    chk("d_req_ready", 32'(req_ready), 32'(oh));
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("d_exec_no_rsp", 32'(rsp_valid), 32'(0));
    chk("d_exec_busy",   32'(busy),      32'(1));
    step();
    @(negedge clk);
    chk("d_rsp_valid_t2", 32'(rsp_valid), 32'(oh));
    chk("d_rsp_id",       32'(rsp_id),    32'(id));
    chk("d_rsp_r",        32'(rsp_r),     32'(er));
    chk("d_rsp_flags",    32'(rsp_flags), 32'(ef));
    chk("d_rsp_err",      32'(rsp_err),   32'(ee));
    for (int i = 0; i < hold; i++) begin
      step();
      rsp_ready = ~oh;
      @(negedge clk);
      chk("d_hold_valid", 32'(rsp_valid), 32'(oh));
      chk("d_hold_r",     32'(rsp_r),     32'(er));
      chk("d_hold_flags", 32'(rsp_flags), 32'(ef));
      chk("d_hold_busy",  32'(busy),      32'(1));
    end
    step();
    rsp_ready = oh;
    @(negedge clk);
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("d_back_idle",   32'(busy),      32'(0));
    chk("d_rsp_dropped", 32'(rsp_valid), 32'(0));
  endtask

  int grants[$];

  initial begin
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0; req_op0 = '0; req_op1 = '0;

    // Reset held two cycles with both requesters valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_alu_a",     32'(alu_a),     32'(0));
    chk("rst_alu_b",     32'(alu_b),     32'(0));
    chk("rst_alu_op",    32'(alu_op),    32'(0));
    step();
    rst_n = 1'b1; req_valid = 2'b00;
    @(negedge clk);

    do_req(1'b0, 6'b101010, 6'b110011, 2'b00, 1, 6'b100110, 4'b1100, 1'b0);
    do_req(1'b1, 6'b000001, 6'b000001, 2'b01, 0, 6'b100000, 4'b1100, 1'b0);
    do_req(1'b0, 6'b000000, 6'b000000, 2'b01, 5, 6'b000000, 4'b0001, 1'b0);
    do_req(1'b1, 6'h3F,     6'h3F,     2'b11, 0, 6'b000000, 4'b0001, 1'b1);

    // Reset during EXEC abandons the op.
    step();
    req_valid = 2'b01; req_a0 = 6'h15; req_b0 = 6'h0A; req_op0 = 2'b00;
    @(negedge clk);
    step();
    req_valid = 2'b00; rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy_exec", 32'(busy), 32'(1));
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", 32'(rsp_valid), 32'(0));
      chk("mid_rst_idle",   32'(busy),      32'(0));
      step();
    end

    // Both requesters valid from reset: grants must alternate starting at 0.
    rst_n = 1'b0; req_valid = 2'b11;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) grants.push_back(int'(req_ready[1]));
      step();
      rsp_ready = 2'($urandom_range(0, 3));
      req_a0 = 6'($urandom_range(0, 63)); req_b0 = 6'($urandom_range(0, 63));
      req_a1 = 6'($urandom_range(0, 63)); req_b1 = 6'($urandom_range(0, 63));
      req_op0 = 2'($urandom_range(0, 3)); req_op1 = 2'($urandom_range(0, 3));
    end
    chk("alt_enough_grants", 32'(grants.size() >= 4), 32'(1));
    for (int i = 0; i < grants.size(); i++) begin
      if (i < 4) chk("alt_order", 32'(grants[i]), 32'(i % 2));
      else       chk("alt_strict", 32'(grants[i]), 32'(grants[i-1] ^ 1));
    end

    // Random traffic including occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step();
      rst_n     = ($urandom_range(0, 63) != 0);
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      req_a0 = 6'($urandom_range(0, 63)); req_b0 = 6'($urandom_range(0, 63));
      req_a1 = 6'($urandom_range(0, 63)); req_b1 = 6'($urandom_range(0, 63));
      req_op0 = 2'($urandom_range(0, 3)); req_op1 = 2'($urandom_range(0, 3));
    end
    step();
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
